// File: rtl/hazard_response.sv
// Hazard response block: ID/EX pipeline register with stall/flush bubbling,
// EX-stage operand forwarding muxes, fetch write enables and event counters.
module hazard_response (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic        loaduse_stall,
    input  logic        branch_flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_ALUSrc,
    input  logic [3:0]  id_ALUOp,
    input  logic [31:0] EXMEM_ALU_Result,
    input  logic [31:0] MEMWB_Write_Data,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_valid,
    output logic [4:0]  IDEX_rs,
    output logic [4:0]  IDEX_rt,
    output logic [4:0]  IDEX_rd,
    output logic        IDEX_RegWrite,
    output logic        IDEX_MemRead,
    output logic        IDEX_MemWrite,
    output logic        IDEX_ALUSrc,
    output logic [3:0]  IDEX_ALUOp,
    output logic [31:0] IDEX_imm,
    output logic [31:0] ex_opA,
    output logic [31:0] ex_opB,
    output logic [31:0] ex_store_data,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    logic              bubble;
    logic              stall_event;
    logic [DATA_W-1:0] idex_rs_data;
    logic [DATA_W-1:0] idex_rt_data;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Event decode: a flush overrides a simultaneous load-use stall.
    always_comb begin
        bubble      = loaduse_stall | branch_flush;
        stall_event = loaduse_stall & ~branch_flush;
    end

    // Fetch write enables: held low only by a non-flushed stall or by reset.
    always_comb begin
        PC_Write   = ~reset & ~stall_event;
        IFID_Write = ~reset & ~stall_event;
    end

    // ID/EX register: capture the ID stage or insert a bubble on every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IDEX_valid    <= 1'b0;
            IDEX_rs       <= '0;
            IDEX_rt       <= '0;
            IDEX_rd       <= '0;
            IDEX_RegWrite <= 1'b0;
            IDEX_MemRead  <= 1'b0;
            IDEX_MemWrite <= 1'b0;
            IDEX_ALUSrc   <= 1'b0;
            IDEX_ALUOp    <= '0;
            IDEX_imm      <= '0;
            idex_rs_data  <= '0;
            idex_rt_data  <= '0;
        end else if (bubble) begin
            IDEX_valid    <= 1'b0;
            IDEX_rs       <= '0;
            IDEX_rt       <= '0;
            IDEX_rd       <= '0;
            IDEX_RegWrite <= 1'b0;
            IDEX_MemRead  <= 1'b0;
            IDEX_MemWrite <= 1'b0;
            IDEX_ALUSrc   <= 1'b0;
            IDEX_ALUOp    <= '0;
            IDEX_imm      <= '0;
            idex_rs_data  <= '0;
            idex_rt_data  <= '0;
        end else begin
            IDEX_valid    <= id_valid;
            IDEX_rs       <= id_rs;
            IDEX_rt       <= id_rt;
            IDEX_rd       <= id_rd;
            IDEX_RegWrite <= id_RegWrite;
            IDEX_MemRead  <= id_MemRead;
            IDEX_MemWrite <= id_MemWrite;
            IDEX_ALUSrc   <= id_ALUSrc;
            IDEX_ALUOp    <= id_ALUOp;
            IDEX_imm      <= id_imm;
            idex_rs_data  <= id_rs_data;
            idex_rt_data  <= id_rt_data;
        end
    end

    // Operand forwarding; the reserved code 11 falls back to register data.
    always_comb begin
        fwd_a = idex_rs_data;
        fwd_b = idex_rt_data;
        case (ForwardA)
            FWD_MEMWB: fwd_a = MEMWB_Write_Data;
            FWD_EXMEM: fwd_a = EXMEM_ALU_Result;
            FWD_RF:    fwd_a = idex_rs_data;
            default:   fwd_a = idex_rs_data;
        endcase
        case (ForwardB)
            FWD_MEMWB: fwd_b = MEMWB_Write_Data;
            FWD_EXMEM: fwd_b = EXMEM_ALU_Result;
            FWD_RF:    fwd_b = idex_rt_data;
            default:   fwd_b = idex_rt_data;
        endcase
    end

    // EX operands: immediate replaces operand B when ALUSrc is set.
    always_comb begin
        ex_opA        = fwd_a;
        ex_opB        = IDEX_ALUSrc ? IDEX_imm : fwd_b;
        ex_store_data = fwd_b;
    end

    // Saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_event && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Saturating flush counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_count <= '0;
        end else if (branch_flush && (flush_count != CNT_MAX)) begin
            flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_response.sv
// Self-checking bench for hazard_response: directed scenarios plus randomized
// traffic compared against a behavioural pipeline-register model.
module tb_hazard_response;

    logic        clk;
    logic        reset;
    logic [1:0]  ForwardA, ForwardB;
    logic        loaduse_stall, branch_flush;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc;
    logic [3:0]  id_ALUOp;
    logic [31:0] EXMEM_ALU_Result, MEMWB_Write_Data;
    logic        PC_Write, IFID_Write;
    logic        IDEX_valid;
    logic [4:0]  IDEX_rs, IDEX_rt, IDEX_rd;
    logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_ALUSrc;
    logic [3:0]  IDEX_ALUOp;
    logic [31:0] IDEX_imm, ex_opA, ex_opB, ex_store_data;
    logic [15:0] stall_count, flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic        m_valid, m_regwrite, m_memread, m_memwrite, m_alusrc;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [3:0]  m_aluop;
    logic [31:0] m_imm, m_rs_data, m_rt_data;
    int          m_stalls, m_flushes;

    hazard_response dut (
        .clk(clk), .reset(reset),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .loaduse_stall(loaduse_stall), .branch_flush(branch_flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
        .EXMEM_ALU_Result(EXMEM_ALU_Result), .MEMWB_Write_Data(MEMWB_Write_Data),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write),
        .IDEX_valid(IDEX_valid), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt), .IDEX_rd(IDEX_rd),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_MemWrite(IDEX_MemWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
        .IDEX_ALUOp(IDEX_ALUOp), .IDEX_imm(IDEX_imm),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_store_data(ex_store_data),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [1:0] code, input logic [31:0] reg_data);
        if (code == 2'b10) return EXMEM_ALU_Result;
        if (code == 2'b01) return MEMWB_Write_Data;
        return reg_data;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_alusrc = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_aluop = 0;
        m_imm = 0; m_rs_data = 0; m_rt_data = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // What one clock edge does, from the block's stated behaviour
    task automatic model_edge();
        if (loaduse_stall || branch_flush) begin
            m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_alusrc = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_aluop = 0;
            m_imm = 0; m_rs_data = 0; m_rt_data = 0;
        end else begin
            m_valid = id_valid; m_regwrite = id_RegWrite; m_memread = id_MemRead;
            m_memwrite = id_MemWrite; m_alusrc = id_ALUSrc;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_aluop = id_ALUOp;
            m_imm = id_imm; m_rs_data = id_rs_data; m_rt_data = id_rt_data;
        end
        if (branch_flush) m_flushes = (m_flushes + 1 > 65535) ? 65535 : m_flushes + 1;
        else if (loaduse_stall) m_stalls = (m_stalls + 1 > 65535) ? 65535 : m_stalls + 1;
    endtask

    task automatic check_comb();
        logic hold;
        hold = reset || (loaduse_stall && !branch_flush);
        chk("PC_Write", 32'(PC_Write), 32'(!hold));
        chk("IFID_Write", 32'(IFID_Write), 32'(!hold));
    endtask

    task automatic check_all();
        logic [31:0] fb;
        fb = fwd_ref(ForwardB, m_rt_data);
        check_comb();
        chk("IDEX_valid", 32'(IDEX_valid), 32'(m_valid));
        chk("IDEX_rs", 32'(IDEX_rs), 32'(m_rs));
        chk("IDEX_rt", 32'(IDEX_rt), 32'(m_rt));
        chk("IDEX_rd", 32'(IDEX_rd), 32'(m_rd));
        chk("IDEX_RegWrite", 32'(IDEX_RegWrite), 32'(m_regwrite));
        chk("IDEX_MemRead", 32'(IDEX_MemRead), 32'(m_memread));
        chk("IDEX_MemWrite", 32'(IDEX_MemWrite), 32'(m_memwrite));
        chk("IDEX_ALUSrc", 32'(IDEX_ALUSrc), 32'(m_alusrc));
        chk("IDEX_ALUOp", 32'(IDEX_ALUOp), 32'(m_aluop));
        chk("IDEX_imm", IDEX_imm, m_imm);
        chk("ex_opA", ex_opA, fwd_ref(ForwardA, m_rs_data));
        chk("ex_opB", ex_opB, m_alusrc ? m_imm : fb);
        chk("ex_store_data", ex_store_data, fb);
        chk("stall_count", 32'(stall_count), 32'(m_stalls));
        chk("flush_count", 32'(flush_count), 32'(m_flushes));
    endtask

    // One clock: check fetch enables before the edge, everything after it
    task automatic step();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic randomize_id();
        id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
        id_rd = 5'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm = $urandom; id_RegWrite = 1'($urandom); id_MemRead = 1'($urandom);
        id_MemWrite = 1'($urandom); id_ALUSrc = 1'($urandom); id_ALUOp = 4'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        ForwardA = 0; ForwardB = 0; loaduse_stall = 0; branch_flush = 0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_RegWrite = 0; id_MemRead = 0; id_MemWrite = 0; id_ALUSrc = 0; id_ALUOp = 0;
        EXMEM_ALU_Result = 32'h22; MEMWB_Write_Data = 32'h33;
        model_reset();

        // Reset state
        #1;
        check_all();
        #1 reset = 1'b0;

        // Normal capture
        randomize_id();
        id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h11; id_ALUSrc = 0; id_MemRead = 0;
        step();
        chk("cap_rs", 32'(IDEX_rs), 32'd3);
        chk("cap_opA", ex_opA, 32'h11);

        // Forward decode in the same cycle, no edge in between
        ForwardA = 2'b10; #1; chk("fwdA_10", ex_opA, 32'h22);
        ForwardA = 2'b01; #1; chk("fwdA_01", ex_opA, 32'h33);
        ForwardA = 2'b11; #1; chk("fwdA_11", ex_opA, 32'h11);
        ForwardA = 2'b00;

        // Two-cycle load-use stall
        randomize_id();
        id_MemRead = 1; id_valid = 1;
        loaduse_stall = 1;
        repeat (2) begin
            #1;
            chk("stall_pc", 32'(PC_Write), 32'd0);
            chk("stall_ifid", 32'(IFID_Write), 32'd0);
            step();
            chk("stall_valid", 32'(IDEX_valid), 32'd0);
            chk("stall_memread", 32'(IDEX_MemRead), 32'd0);
        end
        chk("stall_count2", 32'(stall_count), 32'd2);

        // Stall and flush together: flush wins
        branch_flush = 1;
        #1;
        chk("both_pc", 32'(PC_Write), 32'd1);
        chk("both_ifid", 32'(IFID_Write), 32'd1);
        step();
        chk("both_valid", 32'(IDEX_valid), 32'd0);
        chk("both_flush", 32'(flush_count), 32'd1);
        chk("both_stall", 32'(stall_count), 32'd2);
        loaduse_stall = 0; branch_flush = 0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            randomize_id();
            ForwardA = 2'($urandom); ForwardB = 2'($urandom);
            loaduse_stall = ($urandom_range(0, 3) == 0);
            branch_flush = ($urandom_range(0, 7) == 0);
            EXMEM_ALU_Result = $urandom; MEMWB_Write_Data = $urandom;
            step();
        end

        // Async reset between edges with a valid instruction in ID/EX
        loaduse_stall = 0; branch_flush = 0;
        randomize_id();
        id_valid = 1;
        step();
        chk("pre_rst_valid", 32'(IDEX_valid), 32'd1);
        loaduse_stall = 1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 32'(IDEX_valid), 32'd0);
        chk("arst_stall", 32'(stall_count), 32'd0);
        chk("arst_flush", 32'(flush_count), 32'd0);
        chk("arst_pc", 32'(PC_Write), 32'd0);
        check_all();
        #1 reset = 1'b0;
        loaduse_stall = 0;
        randomize_id();
        step();

        // Stall counter saturation
        reset = 1'b1; model_reset(); #1 reset = 1'b0;
        loaduse_stall = 1; branch_flush = 0;
        repeat (65534) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        chk("sat_pre", 32'(stall_count), 32'hFFFE);
        repeat (3) step();
        chk("sat_stall", 32'(stall_count), 32'hFFFF);
        loaduse_stall = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
